// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (adds the CHK state).
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_CHK   = 3'd5
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES_DEF  = 2;

  // Width able to hold values 0..n inclusive (the word count may equal SIZE).
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Little-endian byte-to-word assembler: a lane counter plus a 32-bit
// insert register. word_nxt is the word including the byte being loaded,
// so the caller can capture a finished word on the same edge.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  din,
  output logic [31:0] word_nxt,
  output logic        word_full
);

  localparam int LANE_W = $clog2(BYTES_PER_WORD);

  logic [LANE_W-1:0] lane;
  logic [31:0]       word;

  // Current word with the incoming byte dropped into its lane.
  always_comb begin
    word_nxt = word;
    word_nxt[8*lane +: 8] = din;
  end

  // High when this load fills the top lane and completes the word.
  assign word_full = load && (lane == LANE_W'(BYTES_PER_WORD - 1));

  // Lane counter wraps after the top lane; every lane is rewritten per word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane <= '0;
      word <= '0;
    end else if (clear) begin
      lane <= '0;
      word <= '0;
    end else if (load) begin
      word <= word_nxt;
      lane <= lane + 1'b1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a length header (little-endian word
// count) followed by little-endian instruction bytes, and writes each
// assembled word into the instruction RAM while holding the CPU in reset.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN -- expects one trailing
// byte equal to the XOR of all data bytes; a mismatch sets err.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | after reset, waiting for start
// S_LEN   | collecting LEN_BYTES header bytes, LSB first
// S_DATA  | collecting the four bytes of the current word
// S_WRITE | one-cycle RAM write of the assembled word
// S_CHK   | (checksum build) waiting for the trailing XOR byte
// S_DONE  | session finished; done/err hold until next start or reset
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int SIZE      = 64,
  parameter int LEN_BYTES = LEN_BYTES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int IW    = idx_width(SIZE);
  localparam int LW    = idx_width(LEN_BYTES);
  localparam int LBITS = 8 * LEN_BYTES;

  state_t            state;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     idx_inc;
  logic [IW-1:0]     nwords;
  logic [LW-1:0]     len_cnt;
  logic [LBITS-1:0]  len_acc;
  logic [LBITS-1:0]  len_nxt;
  logic [LBITS-1:0]  byte_ext;
  logic              xfer;
  logic              pk_clear;
  logic              pk_load;
  logic              word_full;
  logic [31:0]       word_nxt;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  assign xfer     = byte_valid & byte_ready;
  assign pk_clear = start && ((state == S_IDLE) || (state == S_DONE));
  assign pk_load  = xfer && (state == S_DATA);
  assign idx_inc  = idx + 1'b1;

  // Length value including the header byte currently being accepted.
  always_comb begin
    byte_ext      = '0;
    byte_ext[7:0] = byte_data;
    len_nxt       = len_acc | (byte_ext << (8 * len_cnt));
  end

  imem_word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (pk_clear),
    .load      (pk_load),
    .din       (byte_data),
    .word_nxt  (word_nxt),
    .word_full (word_full)
  );

  // Session sequencer; all outputs are registered and set on transitions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      byte_ready <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_hold   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      idx        <= '0;
      nwords     <= '0;
      len_cnt    <= '0;
      len_acc    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_LEN;
            byte_ready <= 1'b1;
            busy       <= 1'b1;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            idx        <= '0;
            len_cnt    <= '0;
            len_acc    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
          end
        end
        S_LEN: begin
          if (xfer) begin
            len_acc <= len_nxt;
            len_cnt <= len_cnt + 1'b1;
            if (len_cnt == LW'(LEN_BYTES - 1)) begin
              nwords <= IW'(len_nxt);
              if (len_nxt > LBITS'(SIZE)) begin
                // Program too large: abort without touching the RAM.
                state      <= S_DONE;
                byte_ready <= 1'b0;
                busy       <= 1'b0;
                cpu_hold   <= 1'b0;
                done       <= 1'b1;
                err        <= 1'b1;
              end else if (len_nxt == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state      <= S_CHK;
`else
                state      <= S_DONE;
                byte_ready <= 1'b0;
                busy       <= 1'b0;
                cpu_hold   <= 1'b0;
                done       <= 1'b1;
`endif
              end else begin
                state <= S_DATA;
                idx   <= '0;
              end
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= csum ^ byte_data;
`endif
            if (word_full) begin
              state      <= S_WRITE;
              byte_ready <= 1'b0;
              mem_we     <= 1'b1;
              mem_addr   <= 32'(idx);
              mem_wdata  <= word_nxt;
            end
          end
        end
        S_WRITE: begin
          idx <= idx_inc;
          if (idx_inc == nwords) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state      <= S_CHK;
            byte_ready <= 1'b1;
`else
            state      <= S_DONE;
            busy       <= 1'b0;
            cpu_hold   <= 1'b0;
            done       <= 1'b1;
`endif
          end else begin
            state      <= S_DATA;
            byte_ready <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (xfer) begin
            err        <= (byte_data != csum);
            state      <= S_DONE;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            cpu_hold   <= 1'b0;
            done       <= 1'b1;
          end
        end
`endif
        default: begin
          state      <= S_IDLE;
          byte_ready <= 1'b0;
          busy       <= 1'b0;
          cpu_hold   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of load sessions plus randomized sessions,
// checked against a byte-stream model; hand sequences for idle, misuse and
// mid-session reset. Honours IMEM_LOADER_CHECKSUM_EN (sends trailing byte).
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int SIZE = 64;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready, mem_we, cpu_hold, busy, done, err;
  logic [31:0] mem_addr, mem_wdata;

  imem_loader #(.SIZE(SIZE), .LEN_BYTES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int nf;
    int stall;
    bit bad;
    int exp_w;
    bit exp_err;
  } vec_t;

  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   xfer_cyc = -100;
  wr_t  wlog[$];
  wr_t  exp_q[$];
  logic [7:0] stream[$];
  vec_t tbl[9];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  always @(posedge clk) cyc++;

  // Write monitor: logs RAM writes and checks their timing.
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      wlog.push_back('{mem_addr, mem_wdata});
      chk("we_latency", 64'(cyc), 64'(xfer_cyc));
      chk("ready_low_in_write", {63'b0, byte_ready}, 64'd0);
      chk("addr_in_range", {63'b0, (mem_addr < SIZE)}, 64'd1);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int g = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (!byte_ready) begin
      n_vec++;
      n_bad++;
      $display("FAIL byte_accept: byte %0h still refused after 20 cycles", b);
    end else begin
      xfer_cyc = cyc + 1;
      chk("hold_during_load", {63'b0, cpu_hold}, 64'd1);
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  // Model: header LSB first, then words little-endian, optional XOR byte.
  task automatic build_stream(input int nf, input bit bad);
    logic [7:0] x = 8'h00;
    int nw;
    stream.delete();
    exp_q.delete();
    stream.push_back(nf[7:0]);
    stream.push_back(nf[15:8]);
    nw = (nf <= SIZE) ? nf : 0;
    for (int w = 0; w < nw; w++) begin
      logic [31:0] d = $urandom;
      for (int k = 0; k < 4; k++) begin
        stream.push_back(d[8*k +: 8]);
        x ^= d[8*k +: 8];
      end
      exp_q.push_back('{32'(w), d});
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (nf <= SIZE) stream.push_back(bad ? (x ^ 8'h01) : x);
`else
    x = x ^ {7'b0, bad};
`endif
  endtask

  // Runs one session; on entry and exit the bench sits on a falling edge.
  task automatic play(input int stall, input bit fixed, input int start_at);
    int g = 0;
    wlog.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_state", {59'b0, busy, cpu_hold, done, err, byte_ready}, 64'b11001);
    for (int i = 0; i < stream.size(); i++) begin
      if (i == start_at) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      if (stall > 0) repeat (fixed ? stall : $urandom_range(0, stall)) @(negedge clk);
      send_byte(stream[i]);
    end
    while (!done && g < 60) begin
      @(negedge clk);
      g++;
    end
    chk("session_done", {63'b0, done}, 64'd1);
    chk("released", {61'b0, busy, cpu_hold, byte_ready}, 64'd0);
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("done_refuses", {63'b0, byte_ready}, 64'd0);
    end
    byte_valid = 1'b0;
  endtask

  task automatic check_session(input string tag, input int exp_w, input bit exp_err);
    chk({tag, "_writes"}, 64'(wlog.size()), 64'(exp_w));
    chk({tag, "_err"}, {63'b0, err}, {63'b0, exp_err});
    for (int i = 0; i < exp_q.size() && i < wlog.size(); i++) begin
      chk({tag, "_addr"}, {32'b0, wlog[i].addr}, {32'b0, exp_q[i].addr});
      chk({tag, "_data"}, {32'b0, wlog[i].data}, {32'b0, exp_q[i].data});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1,   0, 1'b0, 1,  1'b0};
    tbl[1] = '{3,   3, 1'b0, 3,  1'b0};
    tbl[2] = '{0,   0, 1'b0, 0,  1'b0};
    tbl[3] = '{64,  0, 1'b0, 64, 1'b0};
    tbl[4] = '{65,  0, 1'b0, 0,  1'b1};
    tbl[5] = '{256, 1, 1'b0, 0,  1'b1};
    tbl[6] = '{5,   2, 1'b1, 5,  CSUM_ON};
    tbl[7] = '{2,   1, 1'b0, 2,  1'b0};
    tbl[8] = '{0,   0, 1'b1, 0,  CSUM_ON};

    // Reset state, then 20 idle cycles with bytes offered.
    repeat (2) @(negedge clk);
    chk("reset_flags", {58'b0, byte_ready, mem_we, cpu_hold, busy, done, err}, 64'd0);
    chk("reset_addr", {32'b0, mem_addr}, 64'd0);
    chk("reset_wdata", {32'b0, mem_wdata}, 64'd0);
    rst = 1'b0;
    byte_valid = 1'b1;
    byte_data  = 8'h5A;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_quiet", {58'b0, byte_ready, mem_we, cpu_hold, busy, done, err}, 64'd0);
    end
    byte_valid = 1'b0;
    chk("idle_no_writes", 64'(wlog.size()), 64'd0);

    // Basic program; checksum byte is the XOR of the eight data bytes (0xB0).
    stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    exp_q  = '{'{32'd0, 32'h00100513}, '{32'd1, 32'h00200593}};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream.push_back(8'hB0);
`endif
    play(0, 1'b0, -1);
    check_session("basic", 2, 1'b0);
    play(3, 1'b1, -1);
    check_session("basic_stall", 2, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream[stream.size() - 1] = 8'hB1;
    play(0, 1'b0, -1);
    check_session("basic_badsum", 2, 1'b1);
`endif

    // Table-driven sessions with random payloads.
    for (int t = 0; t < 9; t++) begin
      build_stream(tbl[t].nf, tbl[t].bad);
      play(tbl[t].stall, 1'b0, -1);
      check_session($sformatf("tbl%0d", t), tbl[t].exp_w, tbl[t].exp_err);
    end

    // start pulse in the middle of the first word is ignored.
    build_stream(2, 1'b0);
    play(1, 1'b0, 5);
    check_session("start_in_data", 2, 1'b0);

    // Reset in the middle of the second word, then a clean reload.
    build_stream(2, 1'b0);
    wlog.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(stream[i]);
    rst = 1'b1;
    #1;
    chk("midrst_flags", {58'b0, byte_ready, mem_we, cpu_hold, busy, done, err}, 64'd0);
    chk("midrst_addr", {32'b0, mem_addr}, 64'd0);
    chk("midrst_wdata", {32'b0, mem_wdata}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_writes", 64'(wlog.size()), 64'd1);
    if (wlog.size() > 0) chk("midrst_first_word", {32'b0, wlog[0].data}, {32'b0, exp_q[0].data});
    build_stream(3, 1'b0);
    play(0, 1'b0, -1);
    check_session("reload", 3, 1'b0);

    // Randomized sessions checked against the stream model.
    for (int r = 0; r < 6; r++) begin
      int nf;
      bit bad;
      nf  = $urandom_range(0, 70);
      bad = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      bad = 1'($urandom_range(0, 1));
`endif
      build_stream(nf, bad);
      play($urandom_range(0, 2), 1'b0, -1);
      check_session($sformatf("rand%0d", r), (nf <= SIZE) ? nf : 0,
                    (nf > SIZE) || (bad && CSUM_ON));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
